// File: rtl/conv_sequencer.sv
// Frame-level sequencer for the two-layer 3x3 convolution pipeline: runs layer 1, then layer 2, with abort and stall watchdog.
// Optional define CONV_SEQ_PERF_EN adds a 32-bit busy-cycle counter output (cycle_cnt).
module conv_sequencer #(
  parameter int L1_DIM  = 30,
  parameter int L2_DIM  = 28,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        l1_done,
  input  logic        l2_done,
  output logic        l1_enable,
  output logic        l2_enable,
  output logic        pipe_clr,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        spurious
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  localparam int L1_TOTAL = L1_DIM * L1_DIM;
  localparam int L2_TOTAL = L2_DIM * L2_DIM;
  localparam int L1_W     = $clog2(L1_TOTAL) + 1;
  localparam int L2_W     = $clog2(L2_TOTAL) + 1;
  localparam int WD_W     = $clog2(TIMEOUT) + 1;

  // A strobe seen while the counter holds *_LAST is the final one of its layer.
  localparam logic [L1_W-1:0] L1_LAST = L1_W'(L1_TOTAL - 1);
  localparam logic [L2_W-1:0] L2_LAST = L2_W'(L2_TOTAL - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_RUN,
    S_L2_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [L1_W-1:0]   l1_cnt_reg, l1_cnt_next;
  logic [L2_W-1:0]   l2_cnt_reg, l2_cnt_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              spurious_reg, spurious_next;
  logic              frame_done_reg, frame_done_next;
  logic              pipe_clr_reg, pipe_clr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      l1_cnt_reg     <= '0;
      l2_cnt_reg     <= '0;
      wd_reg         <= '0;
      spurious_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      pipe_clr_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      l1_cnt_reg     <= l1_cnt_next;
      l2_cnt_reg     <= l2_cnt_next;
      wd_reg         <= wd_next;
      spurious_reg   <= spurious_next;
      frame_done_reg <= frame_done_next;
      pipe_clr_reg   <= pipe_clr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    l1_cnt_next     = l1_cnt_reg;
    l2_cnt_next     = l2_cnt_reg;
    wd_next         = wd_reg;
    frame_done_next = 1'b0;
    pipe_clr_next   = 1'b0;
    spurious_next   = spurious_reg
                    | (l1_done && (state_reg != S_L1_RUN))
                    | (l2_done && (state_reg != S_L2_RUN));

    case (state_reg)
      S_IDLE, S_DONE: begin
        // abort is otherwise a no-op here, but still suppresses a coincident start
        if (start && !abort) begin
          state_next  = S_L1_RUN;
          l1_cnt_next = '0;
          l2_cnt_next = '0;
          wd_next     = '0;
        end
      end

      S_ERROR: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next  = S_L1_RUN;
          l1_cnt_next = '0;
          l2_cnt_next = '0;
          wd_next     = '0;
        end
      end

      S_L1_RUN: begin
        if (abort) begin
          state_next    = S_IDLE;
          pipe_clr_next = 1'b1;
          wd_next       = '0;
        end else if (l1_done) begin
          l1_cnt_next = l1_cnt_reg + 1'b1;
          wd_next     = '0;
          if (l1_cnt_reg == L1_LAST) begin
            state_next = S_L2_RUN;
          end
        end else if (wd_reg == WD_LAST) begin
          state_next    = S_ERROR;
          pipe_clr_next = 1'b1;
          wd_next       = '0;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      S_L2_RUN: begin
        if (abort) begin
          state_next    = S_IDLE;
          pipe_clr_next = 1'b1;
          wd_next       = '0;
        end else if (l2_done) begin
          l2_cnt_next = l2_cnt_reg + 1'b1;
          wd_next     = '0;
          if (l2_cnt_reg == L2_LAST) begin
            state_next      = S_DONE;
            frame_done_next = 1'b1;
          end
        end else if (wd_reg == WD_LAST) begin
          state_next    = S_ERROR;
          pipe_clr_next = 1'b1;
          wd_next       = '0;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign l1_enable  = (state_reg == S_L1_RUN);
  assign l2_enable  = (state_reg == S_L2_RUN);
  assign busy       = l1_enable || l2_enable;
  assign err        = (state_reg == S_ERROR);
  assign frame_done = frame_done_reg;
  assign pipe_clr   = pipe_clr_reg;
  assign spurious   = spurious_reg;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] cycle_cnt_reg;
  logic        start_accept;

  // Start is only ever accepted while not busy, so clear and count never coincide.
  assign start_accept = start && !abort && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg <= '0;
    end else if (start_accept) begin
      cycle_cnt_reg <= '0;
    end else if (busy) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
`endif

endmodule
